cust_div_seq: RTL and testbench



---
 rtl/cust_div_pkg.sv | 14 +
 rtl/cust_div_seq_div_step.sv | 23 ++
 rtl/cust_div_seq.sv | 114 +++++++++++
 tb/tb_cust_div_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cust_div_pkg.sv
// Shared state encodings, result-select codes and default sizing for the sequential divider.
package cust_div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic SEL_QUO = 1'b0;
  localparam logic SEL_REM = 1'b1;
endpackage

// File: rtl/cust_div_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
module div_step
  import cust_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder MSB is kept in the shift so divisors with bit WIDTH-1 set still divide correctly.
  assign shifted  = {rem, quo_msb};
  assign trial    = shifted - {1'b0, div};
  assign q_bit    = ~trial[WIDTH];
  assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/cust_div_seq.sv
// Multi-cycle unsigned divider for a custom-instruction slot; n selects quotient or remainder.
// Latency: WIDTH+1 enabled edges after the start edge (1 edge for divide-by-zero).
// Backpressure: clk_en low freezes all state; start is ignored while busy or while done is high.
module cust_div_seq
  import cust_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic             n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);
  state_t           state, nxt_state;
  logic [WIDTH-1:0] quo, nxt_quo;
  logic [WIDTH-1:0] rem, nxt_rem;
  logic [WIDTH-1:0] div, nxt_div;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             sel, nxt_sel;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_done, nxt_busy;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo_msb  (quo[WIDTH-1]),
    .div      (div),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= ST_IDLE;
    else if (clk_en)
      state <= nxt_state;
  end

  always_comb begin
    nxt_state  = state;
    nxt_quo    = quo;
    nxt_rem    = rem;
    nxt_div    = div;
    nxt_cnt    = cnt;
    nxt_sel    = sel;
    nxt_result = result;
    nxt_done   = 1'b0;
    nxt_busy   = busy;
    case (state)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the finished operation and is dropped.
        if (start && !done) begin
          nxt_busy = 1'b1;
          nxt_sel  = n;
          if (datab != '0) begin
            nxt_state = ST_RUN;
            nxt_rem   = '0;
            nxt_quo   = dataa;
            nxt_div   = datab;
            nxt_cnt   = '0;
          end else begin
            nxt_state = ST_FIN;
            nxt_quo   = '1;
            nxt_rem   = dataa;
          end
        end
      end
      ST_RUN: begin
        nxt_rem = step_rem;
        nxt_quo = {quo[WIDTH-2:0], step_q};
        nxt_cnt = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1))
          nxt_state = ST_FIN;
      end
      ST_FIN: begin
        nxt_result = (sel == SEL_REM) ? rem : quo;
        nxt_done   = 1'b1;
        nxt_busy   = 1'b0;
        nxt_state  = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo    <= '0;
      rem    <= '0;
      div    <= '0;
      cnt    <= '0;
      sel    <= SEL_QUO;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else if (clk_en) begin
      quo    <= nxt_quo;
      rem    <= nxt_rem;
      div    <= nxt_div;
      cnt    <= nxt_cnt;
      sel    <= nxt_sel;
      result <= nxt_result;
      done   <= nxt_done;
      busy   <= nxt_busy;
    end
  end
endmodule

// File: tb/tb_cust_div_seq.sv
// Directed and randomized checks of cust_div_seq against a plain-arithmetic divider model.
module tb_cust_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clk_en;
  logic         start;
  logic         n;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic [W-1:0] result;
  logic         done;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cust_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .n       (n),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result),
    .done    (done),
    .busy    (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sel);
    if (b == 0) return sel ? a : {W{1'b1}};
    return sel ? a % b : a / b;
  endfunction

  // Issues one operation, waits (bounded) for done, checks latency, result and the single pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                        input string tag);
    int edges;
    logic [W-1:0] exp;
    exp   = ref_div(a, b, sel);
    dataa = a;
    datab = b;
    n     = sel;
    start = 1'b1;
    step;
    start = 1'b0;
    dataa = $urandom;
    datab = $urandom;
    n     = ~sel;
    check({tag, " busy"}, W'(busy), W'(1));
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      step;
      edges++;
    end
    check({tag, " latency"}, W'(edges), (b == 0) ? W'(1) : W'(W + 1));
    check({tag, " result"}, result, exp);
    check({tag, " busy at done"}, W'(busy), W'(0));
    step;
    check({tag, " done pulse"}, W'(done), W'(0));
  endtask

  initial begin
    int edges;
    int dcount;
    logic [W-1:0] a, b;

    reset_n = 1'b0;
    clk_en  = 1'b0;
    start   = 1'b0;
    n       = 1'b0;
    dataa   = '0;
    datab   = '0;
    repeat (3) step;
    check("reset result", result, '0);
    check("reset done", W'(done), W'(0));
    check("reset busy", W'(busy), W'(0));
    reset_n = 1'b1;
    clk_en  = 1'b1;
    step;

    run_op(332, 22, 1'b0, "332/22 quo");
    run_op(332, 22, 1'b1, "332/22 rem");
    run_op(5, 7, 1'b0, "5/7 quo");
    run_op(5, 7, 1'b1, "5/7 rem");
    run_op(32'hFFFF_FFFF, 1, 1'b0, "max/1 quo");
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, "big divisor rem");
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "msb divisor quo");
    run_op(100, 0, 1'b0, "100/0 quo");
    run_op(100, 0, 1'b1, "100/0 rem");

    // Ignored start while busy plus a clock-enable stall in the middle of the run.
    dataa = 1000;
    datab = 10;
    n     = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (4) step;
    dataa = 9;
    datab = 3;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (5) step;
    clk_en = 1'b0;
    repeat (4) step;
    check("stall busy", W'(busy), W'(1));
    clk_en = 1'b1;
    edges  = 14;
    while (done !== 1'b1 && edges < 200) begin
      step;
      edges++;
    end
    check("stall latency", W'(edges), W'(37));
    check("stall result", result, 100);
    clk_en = 1'b0;
    step;
    check("done held", W'(done), W'(1));
    clk_en = 1'b1;
    step;
    check("done released", W'(done), W'(0));
    dcount = 0;
    repeat (40) begin
      step;
      if (done) dcount++;
    end
    check("no second done", W'(dcount), W'(0));

    // Reset abandons an operation in flight.
    dataa = 1000;
    datab = 10;
    n     = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (9) step;
    reset_n = 1'b0;
    step;
    check("abort done", W'(done), W'(0));
    check("abort result", result, '0);
    check("abort busy", W'(busy), W'(0));
    reset_n = 1'b1;
    dcount  = 0;
    repeat (40) begin
      step;
      if (done) dcount++;
    end
    check("abort no done", W'(dcount), W'(0));
    run_op(2, 23, 1'b1, "2/23 rem");

    // Back-to-back random operations, each start in the cycle after the previous done.
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      case (i % 5)
        0: b = '0;
        1: begin
          a = $urandom_range(0, 1000);
          b = a + $urandom_range(1, 1000);
        end
        2: b = $urandom_range(1, 255);
        3: b = $urandom;
        default: b = $urandom | 32'h8000_0000;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d %0h/%0h", i, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
